// File: rtl/mem_access_unit.sv
// Memory-stage access controller: drives a wait-state data bus, formats load data,
// stalls the pipeline while the bus is busy and flags misaligned or timed-out accesses.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [1:0]  MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  LoadSizeM,
  input  logic        RegWriteM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        RegWriteOutM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic        is_store, is_load, access, misalign, req_ok;
  logic [1:0]  size;  // 0 byte, 1 half, 2 word
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw, lane, fmt;

  // Access decode: a store wins over a load when both are flagged.
  always_comb begin
    is_store = |MemWriteM;
    is_load  = ~is_store & (ResultSrcM == 2'b01);
    access   = is_store | is_load;
    size     = 2'd2;
    if (is_store) begin
      case (MemWriteM)
        2'b01:   size = 2'd0;
        2'b10:   size = 2'd1;
        default: size = 2'd2;
      endcase
    end else begin
      case (LoadSizeM)
        3'b000, 3'b100: size = 2'd0;
        3'b001, 3'b101: size = 2'd1;
        default:        size = 2'd2;
      endcase
    end
    misalign = access & (((size == 2'd1) & ALUResultM[0]) |
                         ((size == 2'd2) & (|ALUResultM[1:0])));
    req_ok   = access & ~misalign;

    case (size)
      2'd0:    be_raw = 4'b0001 << ALUResultM[1:0];
      2'd1:    be_raw = ALUResultM[1] ? 4'b1100 : 4'b0011;
      default: be_raw = 4'b1111;
    endcase

    case (MemWriteM)
      2'b01:   wdata_raw = {4{WriteDataM[7:0]}};
      2'b10:   wdata_raw = {2{WriteDataM[15:0]}};
      default: wdata_raw = WriteDataM;
    endcase

    lane = dmem_rdata >> {ALUResultM[1:0], 3'b000};
    case (LoadSizeM)
      3'b000:  fmt = {{24{lane[7]}}, lane[7:0]};
      3'b100:  fmt = {24'd0, lane[7:0]};
      3'b001:  fmt = {{16{lane[15]}}, lane[15:0]};
      3'b101:  fmt = {16'd0, lane[15:0]};
      default: fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    dmem_req     = 1'b0;
    ReadDataM    = 32'd0;
    RegWriteOutM = 1'b0;
    StallM       = 1'b0;
    MisalignM    = 1'b0;
    BusErrM      = 1'b0;
    case (state_q)
      IDLE: begin
        MisalignM    = misalign;
        RegWriteOutM = RegWriteM & ~misalign;
        if (req_ok) begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            ReadDataM = is_load ? fmt : 32'd0;
          end else begin
            StallM  = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Inputs are frozen by StallM, so the request stays identical.
        dmem_req     = 1'b1;
        StallM       = 1'b1;
        MisalignM    = misalign;
        RegWriteOutM = RegWriteM & ~misalign;
        cnt_d        = cnt_q + 1'b1;
        if (dmem_ready) begin
          rdata_d = is_load ? fmt : 32'd0;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ReadDataM    = rdata_q;
        RegWriteOutM = RegWriteM & ~err_q;
        BusErrM      = err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    dmem_we    = dmem_req & is_store;
    dmem_addr  = dmem_req ? {ALUResultM[31:2], 2'b00} : 32'd0;
    dmem_be    = dmem_req ? be_raw : 4'd0;
    dmem_wdata = (dmem_req & is_store) ? wdata_raw : 32'd0;

    if (rst) begin
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      dmem_addr    = 32'd0;
      dmem_be      = 4'd0;
      dmem_wdata   = 32'd0;
      ReadDataM    = 32'd0;
      RegWriteOutM = 1'b0;
      StallM       = 1'b0;
      MisalignM    = 1'b0;
      BusErrM      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: single-cycle vector table plus wait, timeout
// and mid-wait reset sequences.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, dmem_rdata;
  logic [1:0]  MemWriteM, ResultSrcM;
  logic [2:0]  LoadSizeM;
  logic        RegWriteM, dmem_ready;
  logic        dmem_req, dmem_we, RegWriteOutM, StallM, MisalignM, BusErrM;
  logic [31:0] dmem_addr, dmem_wdata, ReadDataM;
  logic [3:0]  dmem_be;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .LoadSizeM(LoadSizeM), .RegWriteM(RegWriteM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .ReadDataM(ReadDataM), .RegWriteOutM(RegWriteOutM), .StallM(StallM),
    .MisalignM(MisalignM), .BusErrM(BusErrM)
  );

  typedef struct packed {
    logic        req, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata, rd;
    logic        rwo, stall, mis, berr;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] a, wd;
    logic [1:0]  mw, rs;
    logic [2:0]  ls;
    logic        rw, rdy;
    logic [31:0] rdat;
    out_t        exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[16];

  function automatic out_t o(logic req, logic we, logic [31:0] addr, logic [3:0] be,
                             logic [31:0] wdata, logic [31:0] rd, logic rwo,
                             logic stall, logic mis, logic berr);
    out_t r;
    r = '{req, we, addr, be, wdata, rd, rwo, stall, mis, berr};
    return r;
  endfunction

  function automatic vec_t mk(string nm, logic [31:0] a, logic [31:0] wd, logic [1:0] mw,
                              logic [1:0] rs, logic [2:0] ls, logic rw, logic rdy,
                              logic [31:0] rdat, out_t e);
    vec_t v;
    v.name = nm; v.a = a; v.wd = wd; v.mw = mw; v.rs = rs; v.ls = ls;
    v.rw = rw; v.rdy = rdy; v.rdat = rdat; v.exp = e;
    return v;
  endfunction

  task automatic drive(logic [31:0] a, logic [31:0] wd, logic [1:0] mw, logic [1:0] rs,
                       logic [2:0] ls, logic rw, logic rdy, logic [31:0] rdat);
    ALUResultM = a; WriteDataM = wd; MemWriteM = mw; ResultSrcM = rs;
    LoadSizeM = ls; RegWriteM = rw; dmem_ready = rdy; dmem_rdata = rdat;
  endtask

  task automatic cmp(string nm, out_t e);
    out_t act;
    act = {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ReadDataM,
           RegWriteOutM, StallM, MisalignM, BusErrM};
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got req=%b we=%b addr=%h be=%b wdata=%h rd=%h rwo=%b stall=%b mis=%b berr=%b ; want req=%b we=%b addr=%h be=%b wdata=%h rd=%h rwo=%b stall=%b mis=%b berr=%b",
               nm, act.req, act.we, act.addr, act.be, act.wdata, act.rd, act.rwo, act.stall,
               act.mis, act.berr, e.req, e.we, e.addr, e.be, e.wdata, e.rd, e.rwo, e.stall,
               e.mis, e.berr);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  out_t zero, stall_lw200, stall_lw300, stall_lw400;

  initial begin
    zero = '0;
    //            name            addr     wdata      mw    rs    ls    rw   rdy  rdata
    vecs[0]  = mk("sw_0x100",     'h100, 'hDEADBEEF, 2'd3, 2'd0, 3'd0, 1'b0, 1'b1, 'h0,
                  o(1, 1, 'h100, 4'hF, 'hDEADBEEF, 'h0, 0, 0, 0, 0));
    vecs[1]  = mk("sb_0x103",     'h103, 'h000000A5, 2'd1, 2'd0, 3'd0, 1'b0, 1'b1, 'h0,
                  o(1, 1, 'h100, 4'h8, 'hA5A5A5A5, 'h0, 0, 0, 0, 0));
    vecs[2]  = mk("lh_0x102",     'h102, 'h0, 2'd0, 2'd1, 3'd1, 1'b1, 1'b1, 'h80FF1234,
                  o(1, 0, 'h100, 4'hC, 'h0, 'hFFFF80FF, 1, 0, 0, 0));
    vecs[3]  = mk("lhu_0x102",    'h102, 'h0, 2'd0, 2'd1, 3'd5, 1'b1, 1'b1, 'h80FF1234,
                  o(1, 0, 'h100, 4'hC, 'h0, 'h000080FF, 1, 0, 0, 0));
    vecs[4]  = mk("lw_mis_0x202", 'h202, 'h0, 2'd0, 2'd1, 3'd2, 1'b1, 1'b1, 'h1,
                  o(0, 0, 'h0, 4'h0, 'h0, 'h0, 0, 0, 1, 0));
    vecs[5]  = mk("sh_mis_0x001", 'h001, 'h1234, 2'd2, 2'd0, 3'd0, 1'b1, 1'b1, 'h0,
                  o(0, 0, 'h0, 4'h0, 'h0, 'h0, 0, 0, 1, 0));
    vecs[6]  = mk("lb_pos_0x003", 'h003, 'h0, 2'd0, 2'd1, 3'd0, 1'b1, 1'b1, 'h7F000000,
                  o(1, 0, 'h0, 4'h8, 'h0, 'h0000007F, 1, 0, 0, 0));
    vecs[7]  = mk("lb_neg_0x001", 'h001, 'h0, 2'd0, 2'd1, 3'd0, 1'b1, 1'b1, 'h00008000,
                  o(1, 0, 'h0, 4'h2, 'h0, 'hFFFFFF80, 1, 0, 0, 0));
    vecs[8]  = mk("lbu_0x001",    'h001, 'h0, 2'd0, 2'd1, 3'd4, 1'b1, 1'b1, 'h0000F000,
                  o(1, 0, 'h0, 4'h2, 'h0, 'h000000F0, 1, 0, 0, 0));
    vecs[9]  = mk("no_access",    'h104, 'h55, 2'd0, 2'd0, 3'd2, 1'b1, 1'b1, 'hFFFFFFFF,
                  o(0, 0, 'h0, 4'h0, 'h0, 'h0, 1, 0, 0, 0));
    vecs[10] = mk("rs10_no_load", 'h003, 'h0, 2'd0, 2'd2, 3'd0, 1'b1, 1'b1, 'hFFFFFFFF,
                  o(0, 0, 'h0, 4'h0, 'h0, 'h0, 1, 0, 0, 0));
    vecs[11] = mk("store_prio",   'h010, 'hCAFEF00D, 2'd3, 2'd1, 3'd0, 1'b0, 1'b1, 'h11111111,
                  o(1, 1, 'h10, 4'hF, 'hCAFEF00D, 'h0, 0, 0, 0, 0));
    vecs[12] = mk("lw_undef_f3",  'h004, 'h0, 2'd0, 2'd1, 3'd3, 1'b1, 1'b1, 'hAABBCCDD,
                  o(1, 0, 'h4, 4'hF, 'h0, 'hAABBCCDD, 1, 0, 0, 0));
    vecs[13] = mk("sh_0x102",     'h102, 'h1234BEEF, 2'd2, 2'd0, 3'd0, 1'b0, 1'b1, 'h0,
                  o(1, 1, 'h100, 4'hC, 'hBEEFBEEF, 'h0, 0, 0, 0, 0));
    vecs[14] = mk("lh_0x100",     'h100, 'h0, 2'd0, 2'd1, 3'd1, 1'b1, 1'b1, 'hFFFF7FFF,
                  o(1, 0, 'h100, 4'h3, 'h0, 'h00007FFF, 1, 0, 0, 0));
    vecs[15] = mk("lh_mis_0x101", 'h101, 'h0, 2'd0, 2'd1, 3'd1, 1'b1, 1'b1, 'h0,
                  o(0, 0, 'h0, 4'h0, 'h0, 'h0, 0, 0, 1, 0));

    // Reset: outputs forced low even with a live access on the inputs.
    rst = 1'b1;
    drive('h100, 'hDEADBEEF, 2'd3, 2'd0, 3'd0, 1'b1, 1'b1, 'h0);
    @(negedge clk);
    cmp("reset_outputs", zero);
    step();
    step();
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].wd, vecs[i].mw, vecs[i].rs, vecs[i].ls,
            vecs[i].rw, vecs[i].rdy, vecs[i].rdat);
      @(negedge clk);
      cmp(vecs[i].name, vecs[i].exp);
      step();
    end

    // LW with ready three cycles late: stall for four cycles, data in DONE.
    stall_lw200 = o(1, 0, 'h200, 4'hF, 'h0, 'h0, 1, 1, 0, 0);
    drive('h200, 'h0, 2'd0, 2'd1, 3'd2, 1'b1, 1'b0, 'hBAD0BAD0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) dmem_ready = 1'b1;
      if (c == 3) dmem_rdata = 'h12345678;
      @(negedge clk);
      cmp($sformatf("wait_stall_c%0d", c), stall_lw200);
      step();
    end
    dmem_ready = 1'b0;
    dmem_rdata = 'h0;
    @(negedge clk);
    cmp("wait_done", o(0, 0, 'h0, 4'h0, 'h0, 'h12345678, 1, 0, 0, 0));
    step();
    drive('h0, 'h0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 'h0);
    @(negedge clk);
    cmp("wait_back_idle", zero);
    step();

    // Timeout with TIMEOUT=4: IDLE request cycle plus four WAIT cycles, then DONE with error.
    stall_lw300 = o(1, 0, 'h300, 4'hF, 'h0, 'h0, 1, 1, 0, 0);
    drive('h300, 'h0, 2'd0, 2'd1, 3'd2, 1'b1, 1'b0, 'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cmp($sformatf("tmo_stall_c%0d", c), stall_lw300);
      step();
    end
    @(negedge clk);
    cmp("tmo_done", o(0, 0, 'h0, 4'h0, 'h0, 'h0, 0, 0, 0, 1));
    step();
    drive('h0, 'h0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 'h0);
    @(negedge clk);
    cmp("tmo_back_idle", zero);
    step();

    // Reset on the second WAIT cycle abandons the request.
    stall_lw400 = o(1, 0, 'h400, 4'hF, 'h0, 'h0, 1, 1, 0, 0);
    drive('h400, 'h0, 2'd0, 2'd1, 3'd2, 1'b1, 1'b0, 'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      cmp($sformatf("rstw_stall_c%0d", c), stall_lw400);
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    cmp("rstw_in_reset", zero);
    step();
    rst = 1'b0;
    drive('h0, 'h0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 'h0);
    @(negedge clk);
    cmp("rstw_after", zero);
    step();
    drive('h001, 'h0, 2'd0, 2'd1, 3'd4, 1'b1, 1'b1, 'h0000F000);
    @(negedge clk);
    cmp("rstw_lbu", o(1, 0, 'h0, 4'h2, 'h0, 'h000000F0, 1, 0, 0, 0));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
